rsa_exp_engine: RTL and testbench
=================================

RSA_EXP_ENGINE -- requirements
Module: rsa_exp_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8: modulus, message and result width; internal Montgomery datapath is WIDTH+2 bits, R = 2^(WIDTH+2).
REQ-002 SHALL have parameter EWIDTH, default 8: exponent width, independent of WIDTH.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ena  in  1  clock enable; low freezes all state and outputs.
REQ-006 start  in  1  one-cycle request; operands sampled on the same edge.
REQ-007 abort  in  1  synchronous cancel of the operation in flight.
REQ-008 modulus  in  WIDTH  odd modulus N.
REQ-009 exponent  in  EWIDTH  exponent E.
REQ-010 message  in  WIDTH  base X, X < N.
REQ-011 r2  in  WIDTH  precomputed R^2 mod N, supplied by software.
REQ-012 result  out  WIDTH  X^E mod N; held until the next accepted start.
REQ-013 busy  out  1  high from accept until done.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 err  out  1  high with done when N is even or N < 3; result then 0.

Function
REQ-016 SHALL accept start only in IDLE with ena high; start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-017 SHALL latch all operands at accept; input changes afterwards SHALL have no effect.
REQ-018 FSM states: IDLE, CHECK, PRE, LOOP, POST, FIN.
REQ-019 CHECK SHALL last 1 cycle, compute nbits = index of the highest set exponent bit + 1 (0 if E = 0), and go to FIN with err if N is invalid, otherwise to PRE.
REQ-020 A round SHALL be WIDTH+3 cycles: 1 load cycle plus WIDTH+2 bit-serial iterations of both multipliers running in parallel.
REQ-021 PRE SHALL be one round: A = MM(1, r2), Xm = MM(X, r2).
REQ-022 LOOP SHALL be nbits rounds, processing exponent bits LSB first: A = MM(A, Xm) if the bit is 1, else A is held; Xm = MM(Xm, Xm) always.
REQ-023 POST SHALL be one round: Rm = MM(A, 1), followed by one conditional subtraction of N if Rm >= N.
REQ-024 FIN SHALL last 1 cycle: drive result, pulse done, clear busy, then return to IDLE.
REQ-025 Latency from the accepting edge to done high SHALL be (nbits+2)*(WIDTH+3)+1 cycles for valid N, and 1 cycle for invalid N.
REQ-026 E = 0 SHALL yield result 1.
REQ-027 All intermediate values SHALL stay below 2N within WIDTH+2 bits; no overflow is permitted at WIDTH = 2..32.
REQ-028 abort SHALL return the FSM to IDLE on the next edge, deassert busy, produce no done, and leave result unchanged; abort in IDLE has no effect.
REQ-029 abort and start in the same cycle: abort wins and start is dropped.
REQ-030 With ena low, cycle counting SHALL stall; latency counts only ena-high cycles.

Reset
REQ-031 rst SHALL force IDLE, result = 0, busy = 0, done = 0, err = 0, and all datapath registers to 0, immediately and independent of clk and ena.
REQ-032 rst mid-operation SHALL discard the operation; the first start after rst release SHALL be accepted normally.

Structure
REQ-033 State enum, round-length function (WIDTH+3) and datapath width constant SHALL live in shared package rsa_pkg.
REQ-034 One bit-serial Montgomery multiplier sub-module, mont_mul_serial, SHALL be instantiated twice (A path and Xm path).
REQ-035 Control FSM, round counter and exponent bit counter SHALL be local to rsa_exp_engine.

Verification (WIDTH=8, EWIDTH=8, N=33, r2=1 unless stated)
REQ-036 X=5, E=3 -> result=26, err=0, done exactly 45 cycles after the accept edge, busy high throughout.
REQ-037 X=4, E=7 -> 16; then X=16, E=3 -> 4 (encrypt/decrypt round trip).
REQ-038 X=9, E=0 -> result=1, done at cycle 23; N=34 -> err=1, result=0, done at cycle 1.
REQ-039 X=5, E=3 with ena low for 10 cycles mid-LOOP -> done at cycle 55, result=26; a second start during busy is ignored.
REQ-040 abort at cycle 20 -> busy low at cycle 21, no done, result keeps its prior value; a following run gives the correct value.
REQ-041 rst pulse mid-LOOP -> all outputs 0 asynchronously; the next run X=5, E=3 -> 26.

Source files
------------

// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared FSM state type and datapath sizing helpers for the RSA exponentiation engine
package rsa_pkg;

    // Control states of the exponentiation engine
    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PRE,
        LOOP,
        POST,
        FIN
    } rsa_state_t;

    // Montgomery datapath carries two guard bits above the operand width (R = 2^(WIDTH+2))
    localparam int DP_EXTRA = 2;

    // Width of the Montgomery datapath for a given operand width
    function automatic int dp_width(input int width);
        return width + DP_EXTRA;
    endfunction

    // Cycles per multiplier round: one load cycle plus one cycle per datapath bit
    function automatic int round_len(input int width);
        return width + DP_EXTRA + 1;
    endfunction

endpackage

// File: rtl/mont_mul_serial.sv
// rtl/mont_mul_serial.sv - bit-serial Montgomery multiplier, one multiplier bit per step
module mont_mul_serial #(
    parameter int DW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [DW-1:0] i_n,
    output logic [DW-1:0] o_next
);

    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_n;
    logic [DW-1:0] r_s;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_red;
    logic [DW-1:0] w_next;

    // One iteration: add b when the current multiplier bit is set, make the sum even
    // with N, then halve. With a,b < 2N and 4N < R the partial sum stays below b+N,
    // so DW+1 bits hold the pre-shift value and DW bits hold the running sum.
    assign w_sum  = {1'b0, r_s} + (r_a[0] ? {1'b0, r_b} : '0);
    assign w_red  = w_sum + (w_sum[0] ? {1'b0, r_n} : '0);
    assign w_next = DW'(w_red >> 1);

    // The value the running sum takes on the next step; after the final step it is the product
    assign o_next = w_next;

    // Latch operands on load, otherwise advance one multiplier bit per step
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a <= '0;
            r_b <= '0;
            r_n <= '0;
            r_s <= '0;
        end else if (i_load) begin
            r_a <= i_a;
            r_b <= i_b;
            r_n <= i_n;
            r_s <= '0;
        end else if (i_step) begin
            r_s <= w_next;
            r_a <= r_a >> 1;
        end
    end

endmodule

// File: rtl/rsa_exp_engine.sv
// rtl/rsa_exp_engine.sv - modular exponentiation X^E mod N with two parallel Montgomery multipliers
module rsa_exp_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int EWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  modulus,
    input  logic [EWIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]  message,
    input  logic [WIDTH-1:0]  r2,
    output logic [WIDTH-1:0]  result,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DW  = dp_width(WIDTH);
    localparam int RL  = round_len(WIDTH);
    localparam int CW  = $clog2(RL);
    localparam int NBW = $clog2(EWIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(RL - 1);

    rsa_state_t        r_state;
    logic [CW-1:0]     r_cnt;
    logic [NBW-1:0]    r_bits;
    logic [EWIDTH-1:0] r_exp;
    logic [WIDTH-1:0]  r_n;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_r2;
    logic [DW-1:0]     r_a;
    logic [DW-1:0]     r_xm;
    logic [WIDTH-1:0]  r_result;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [NBW-1:0]    w_nbits;
    logic              w_n_bad;
    logic              w_in_round;
    logic              w_load;
    logic              w_step;
    logic              w_round_end;
    logic [DW-1:0]     w_a_op_a;
    logic [DW-1:0]     w_a_op_b;
    logic [DW-1:0]     w_x_op_a;
    logic [DW-1:0]     w_x_op_b;
    logic [DW-1:0]     w_a_next;
    logic [DW-1:0]     w_x_next;

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;

    // Number of significant exponent bits: index of the top set bit plus one
    always_comb begin
        w_nbits = '0;
        for (int i = 0; i < EWIDTH; i++) begin
            if (r_exp[i]) begin
                w_nbits = NBW'(i + 1);
            end
        end
    end

    // Montgomery reduction needs an odd modulus of at least 3
    assign w_n_bad = ~r_n[0] | (r_n < WIDTH'(3));

    // Round sequencing: count 0 loads the multipliers, counts 1..DW step them
    assign w_in_round  = (r_state == PRE) || (r_state == LOOP) || (r_state == POST);
    assign w_load      = ena && w_in_round && (r_cnt == '0);
    assign w_step      = ena && w_in_round && (r_cnt != '0);
    assign w_round_end = (r_cnt == LAST);

    // Operand selection for the A-path and Xm-path multipliers in each phase
    always_comb begin
        w_a_op_a = '0;
        w_a_op_b = '0;
        w_x_op_a = '0;
        w_x_op_b = '0;
        case (r_state)
            PRE: begin
                w_a_op_a = DW'(1);
                w_a_op_b = DW'(r_r2);
                w_x_op_a = DW'(r_x);
                w_x_op_b = DW'(r_r2);
            end
            LOOP: begin
                w_a_op_a = r_a;
                w_a_op_b = r_xm;
                w_x_op_a = r_xm;
                w_x_op_b = r_xm;
            end
            POST: begin
                w_a_op_a = r_a;
                w_a_op_b = DW'(1);
            end
            default: begin
            end
        endcase
    end

    mont_mul_serial #(
        .DW(DW)
    ) u_mul_a (
        .i_clk (clk),
        .i_rst (rst),
        .i_load(w_load),
        .i_step(w_step),
        .i_a   (w_a_op_a),
        .i_b   (w_a_op_b),
        .i_n   (DW'(r_n)),
        .o_next(w_a_next)
    );

    mont_mul_serial #(
        .DW(DW)
    ) u_mul_x (
        .i_clk (clk),
        .i_rst (rst),
        .i_load(w_load),
        .i_step(w_step),
        .i_a   (w_x_op_a),
        .i_b   (w_x_op_b),
        .i_n   (DW'(r_n)),
        .o_next(w_x_next)
    );

    // Control FSM with round counter, exponent bit counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bits   <= '0;
            r_exp    <= '0;
            r_n      <= '0;
            r_x      <= '0;
            r_r2     <= '0;
            r_a      <= '0;
            r_xm     <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else if (ena) begin
            if (abort && (r_state != IDLE)) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                        if (start && !abort) begin
                            r_n     <= modulus;
                            r_exp   <= exponent;
                            r_x     <= message;
                            r_r2    <= r2;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= CHECK;
                        end
                    end
                    CHECK: begin
                        r_cnt <= '0;
                        if (w_n_bad) begin
                            r_result <= '0;
                            r_err    <= 1'b1;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= FIN;
                        end else begin
                            r_bits  <= w_nbits;
                            r_state <= PRE;
                        end
                    end
                    PRE: begin
                        if (w_round_end) begin
                            r_cnt   <= '0;
                            r_a     <= w_a_next;
                            r_xm    <= w_x_next;
                            r_state <= (r_bits == '0) ? POST : LOOP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    LOOP: begin
                        if (w_round_end) begin
                            r_cnt <= '0;
                            if (r_exp[0]) begin
                                r_a <= w_a_next;
                            end
                            r_xm   <= w_x_next;
                            r_exp  <= r_exp >> 1;
                            r_bits <= r_bits - 1'b1;
                            if (r_bits == NBW'(1)) begin
                                r_state <= POST;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    POST: begin
                        if (w_round_end) begin
                            r_cnt    <= '0;
                            r_result <= WIDTH'((w_a_next >= DW'(r_n)) ?
                                               (w_a_next - DW'(r_n)) : w_a_next);
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= FIN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    FIN: begin
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rsa_exp_engine.sv
// tb/tb_rsa_exp_engine.sv - self-checking bench for rsa_exp_engine at WIDTH=8, EWIDTH=8
module tb_rsa_exp_engine;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       start;
    logic       abort;
    logic [7:0] modulus;
    logic [7:0] exponent;
    logic [7:0] message;
    logic [7:0] r2;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic       err;

    int n_tests;
    int n_fail;

    typedef struct {
        int n;
        int e;
        int x;
        int r2v;
        int res;
        int er;
        int lat;
    } vec_t;

    vec_t vecs[12];

    rsa_exp_engine #(
        .WIDTH (8),
        .EWIDTH(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .start   (start),
        .abort   (abort),
        .modulus (modulus),
        .exponent(exponent),
        .message (message),
        .r2      (r2),
        .result  (result),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input longint got, input longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    // Reference: plain square-and-multiply on integers
    function automatic longint ref_modexp(input longint x, input longint e, input longint n);
        longint r;
        longint b;
        longint k;
        r = 1 % n;
        b = x % n;
        k = e;
        while (k > 0) begin
            if (k % 2 == 1) r = (r * b) % n;
            b = (b * b) % n;
            k = k / 2;
        end
        return r;
    endfunction

    function automatic int ref_nbits(input int e);
        int c;
        int t;
        c = 0;
        t = e;
        while (t != 0) begin
            c++;
            t = t / 2;
        end
        return c;
    endfunction

    function automatic bit ref_valid(input int n);
        return (n >= 3) && (n % 2 == 1);
    endfunction

    // Start an operation, scramble the operand inputs afterwards, wait for done
    task automatic run_op(input int t_n, input int t_e, input int t_x, input int t_r2,
                          output int res, output int er, output int lat, output int busy_ok);
        @(negedge clk);
        modulus  = 8'(t_n);
        exponent = 8'(t_e);
        message  = 8'(t_x);
        r2       = 8'(t_r2);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        modulus  = 8'($urandom);
        exponent = 8'($urandom);
        message  = 8'($urandom);
        r2       = 8'($urandom);
        lat      = 0;
        busy_ok  = 1;
        res      = -1;
        er       = -1;
        while (lat < 400) begin
            if (!busy) busy_ok = 0;
            @(negedge clk);
            lat++;
            if (done) begin
                res = int'(result);
                er  = int'(err);
                break;
            end
        end
    endtask

    int res;
    int er;
    int lat;
    int bok;
    int seen;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        ena      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        modulus  = '0;
        exponent = '0;
        message  = '0;
        r2       = '0;

        vecs[0]  = '{33, 3, 5, 1, 26, 0, 45};
        vecs[1]  = '{33, 7, 4, 1, 16, 0, 56};
        vecs[2]  = '{33, 3, 16, 1, 4, 0, 45};
        vecs[3]  = '{33, 0, 9, 1, 1, 0, 23};
        vecs[4]  = '{34, 3, 5, 1, 0, 1, 1};
        vecs[5]  = '{1, 3, 0, 0, 0, 1, 1};
        vecs[6]  = '{2, 3, 1, 0, 0, 1, 1};
        vecs[7]  = '{3, 5, 2, 1, 2, 0, 56};
        vecs[8]  = '{255, 255, 254, 16, 254, 0, 111};
        vecs[9]  = '{33, 1, 7, 1, 7, 0, 34};
        vecs[10] = '{33, 5, 0, 1, 0, 0, 56};
        vecs[11] = '{0, 1, 0, 0, 0, 1, 1};

        repeat (3) @(negedge clk);
        check("reset result", result, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].n, vecs[i].e, vecs[i].x, vecs[i].r2v, res, er, lat, bok);
            check($sformatf("vec%0d result", i), res, vecs[i].res);
            check($sformatf("vec%0d err", i), er, vecs[i].er);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d busy", i), bok, 1);
            @(negedge clk);
            check($sformatf("vec%0d done pulse", i), done, 0);
        end

        for (int i = 0; i < 40; i++) begin
            int n;
            int x;
            int e;
            int rv;
            int want_res;
            int want_lat;
            n = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) != 0) n = n | 1;
            x = (n > 0) ? int'($urandom_range(0, n - 1)) : 0;
            e = int'($urandom_range(0, 255));
            if (ref_valid(n)) begin
                rv       = int'(ref_modexp(longint'(1) << 20, 1, n));
                want_res = int'(ref_modexp(x, e, n));
                want_lat = (ref_nbits(e) + 2) * 11 + 1;
            end else begin
                rv       = int'($urandom_range(0, 255));
                want_res = 0;
                want_lat = 1;
            end
            run_op(n, e, x, rv, res, er, lat, bok);
            check($sformatf("rand%0d N=%0d X=%0d E=%0d result", i, n, x, e), res, want_res);
            check($sformatf("rand%0d err", i), er, ref_valid(n) ? 0 : 1);
            check($sformatf("rand%0d latency", i), lat, want_lat);
        end

        // ena stall mid-LOOP plus an ignored second start while busy
        @(negedge clk);
        @(negedge clk);
        modulus  = 8'd33;
        exponent = 8'd3;
        message  = 8'd5;
        r2       = 8'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            if (lat == 20) ena = 1'b0;
            if (lat == 30) ena = 1'b1;
            if (lat == 35) begin
                start    = 1'b1;
                message  = 8'd7;
                exponent = 8'd5;
            end
            if (lat == 36) start = 1'b0;
            if (done) break;
        end
        check("stall latency", lat, 55);
        check("stall result", result, 26);
        @(negedge clk);
        check("stall done pulse", done, 0);
        check("stall second start ignored", busy, 0);

        // abort mid-LOOP: busy drops, no done, result keeps 26
        @(negedge clk);
        modulus  = 8'd33;
        exponent = 8'd7;
        message  = 8'd4;
        r2       = 8'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("abort busy before", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy after", busy, 0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort no done", seen, 0);
        check("abort result held", result, 26);
        run_op(33, 7, 4, 1, res, er, lat, bok);
        check("post-abort result", res, 16);
        check("post-abort latency", lat, 56);

        // abort and start together: start dropped
        @(negedge clk);
        @(negedge clk);
        modulus  = 8'd33;
        exponent = 8'd3;
        message  = 8'd5;
        start    = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort+start busy", busy, 0);
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort+start no done", seen, 0);
        check("abort+start result held", result, 16);

        // asynchronous reset mid-LOOP with ena low
        @(negedge clk);
        modulus  = 8'd33;
        exponent = 8'd3;
        message  = 8'd5;
        r2       = 8'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        #2;
        ena = 1'b0;
        rst = 1'b1;
        #1;
        check("async rst result", result, 0);
        check("async rst busy", busy, 0);
        check("async rst done", done, 0);
        check("async rst err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        ena = 1'b1;
        run_op(33, 3, 5, 1, res, er, lat, bok);
        check("post-rst result", res, 26);
        check("post-rst latency", lat, 45);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
